// File: rtl/alu_iterative.sv
// ============================================================================
//  Module   : alu_iterative
//  Purpose  : Multi-cycle execute unit. Logic, arithmetic, compare, branch
//             and JAL ops complete in one cycle. Shifts move one bit
//             position per cycle, so a shift by N takes N cycles. Both sides
//             use valid/ready handshakes.
//  Build    : define ALU_FAST_SHIFT_EN to replace the iterative shifter with
//             a one-cycle barrel shifter. The SHIFT state and the counter
//             are then not built. Results are identical in both builds.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous active-low reset
//             in_valid   - operation request
//             in_ready   - unit can accept a request this cycle
//             Operation  - 4-bit operation code
//             SrcA/SrcB  - operands (SrcB low bits = shift amount)
//             out_valid  - result available
//             out_ready  - consumer takes the result
//             ALUResult  - registered result
//             Zero       - branch-taken flag, else (ALUResult == 0)
//             illegal_op - held result came from an undefined code
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iterative #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  illegal_op
);

  localparam logic [3:0] C_OP_AND = 4'b0000;
  localparam logic [3:0] C_OP_OR  = 4'b0001;
  localparam logic [3:0] C_OP_ADD = 4'b0010;
  localparam logic [3:0] C_OP_XOR = 4'b0011;
  localparam logic [3:0] C_OP_SLL = 4'b0100;
  localparam logic [3:0] C_OP_SRL = 4'b0101;
  localparam logic [3:0] C_OP_SUB = 4'b0110;
  localparam logic [3:0] C_OP_SRA = 4'b0111;
  localparam logic [3:0] C_OP_BEQ = 4'b1000;
  localparam logic [3:0] C_OP_BNE = 4'b1001;
  localparam logic [3:0] C_OP_BGE = 4'b1010;
  localparam logic [3:0] C_OP_BLT = 4'b1011;
  localparam logic [3:0] C_OP_SLT = 4'b1100;
  localparam logic [3:0] C_OP_JAL = 4'b1101;

  localparam logic [1:0] S_IDLE  = 2'd0;
`ifndef ALU_FAST_SHIFT_EN
  localparam logic [1:0] S_SHIFT = 2'd1;
`endif
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic                   w_accept;

  logic [DATA_WIDTH-1:0]  r_result;
  logic                   r_zero;
  logic                   r_illegal;

  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic [DATA_WIDTH-1:0]  w_diff;
  logic                   w_lt;
  logic [DATA_WIDTH-1:0]  w_res;
  logic                   w_zero;
  logic                   w_illegal;

  assign w_shamt  = SrcB[SHAMT_WIDTH-1:0];
  assign w_diff   = SrcA - SrcB;
  assign w_lt     = $signed(SrcA) < $signed(SrcB);
  assign w_accept = in_valid && in_ready;

`ifndef ALU_FAST_SHIFT_EN
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]  r_shreg;
  logic [3:0]             r_op;
  logic [DATA_WIDTH-1:0]  w_step;
  logic                   w_start_iter;

  // Amounts 0 and 1 finish at accept; larger amounts iterate. The first
  // bit position is already applied at accept, which keeps the latency of
  // a shift by N at exactly N cycles.
  assign w_start_iter = ((Operation == C_OP_SLL) || (Operation == C_OP_SRL) ||
                         (Operation == C_OP_SRA)) && (w_shamt > SHAMT_WIDTH'(1));

  // One-bit step on the shift register, selected by the captured op.
  always_comb begin
    w_step = r_shreg;
    case (r_op)
      C_OP_SLL: w_step = {r_shreg[DATA_WIDTH-2:0], 1'b0};
      C_OP_SRL: w_step = {1'b0, r_shreg[DATA_WIDTH-1:1]};
      C_OP_SRA: w_step = {r_shreg[DATA_WIDTH-1], r_shreg[DATA_WIDTH-1:1]};
      default:  w_step = r_shreg;
    endcase
  end
`endif

  // Single-cycle result for the op being accepted. In the iterative build
  // a shift yields its value after at most one position; for longer shifts
  // that value seeds the shift register.
  always_comb begin
    w_res     = '0;
    w_zero    = 1'b0;
    w_illegal = 1'b0;
    case (Operation)
      C_OP_AND: w_res = SrcA & SrcB;
      C_OP_OR:  w_res = SrcA | SrcB;
      C_OP_ADD: w_res = SrcA + SrcB;
      C_OP_XOR: w_res = SrcA ^ SrcB;
      C_OP_SUB: w_res = w_diff;
`ifdef ALU_FAST_SHIFT_EN
      C_OP_SLL: w_res = SrcA << w_shamt;
      C_OP_SRL: w_res = SrcA >> w_shamt;
      C_OP_SRA: w_res = $signed(SrcA) >>> w_shamt;
`else
      C_OP_SLL: w_res = (w_shamt == '0) ? SrcA : {SrcA[DATA_WIDTH-2:0], 1'b0};
      C_OP_SRL: w_res = (w_shamt == '0) ? SrcA : {1'b0, SrcA[DATA_WIDTH-1:1]};
      C_OP_SRA: w_res = (w_shamt == '0) ? SrcA : {SrcA[DATA_WIDTH-1], SrcA[DATA_WIDTH-1:1]};
`endif
      C_OP_BEQ, C_OP_BNE, C_OP_BGE, C_OP_BLT: w_res = w_diff;
      C_OP_SLT: w_res = {{(DATA_WIDTH-1){1'b0}}, w_lt};
      C_OP_JAL: w_res = SrcA + DATA_WIDTH'(4);
      default:  w_illegal = 1'b1;
    endcase

    // Branches report "taken"; JAL and illegal codes force 0.
    case (Operation)
      C_OP_BEQ: w_zero = (w_diff == '0);
      C_OP_BNE: w_zero = (w_diff != '0);
      C_OP_BGE: w_zero = !w_lt;
      C_OP_BLT: w_zero = w_lt;
      C_OP_JAL: w_zero = 1'b0;
      4'b1110, 4'b1111: w_zero = 1'b0;
      default:  w_zero = (w_res == '0);
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. IDLE and DONE share accept handling so a retiring
  // result and a new request can pass on the same edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
`ifdef ALU_FAST_SHIFT_EN
          w_state_nxt = S_DONE;
`else
          w_state_nxt = w_start_iter ? S_SHIFT : S_DONE;
`endif
        end else if ((r_state == S_DONE) && out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        if (r_cnt == SHAMT_WIDTH'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = (r_state == S_DONE);
    in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  end

  // --------------------------------------------------------------------------
  // Datapath registers. Nothing is loaded in DONE without an accept, so the
  // held result stays stable under backpressure.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_op      <= '0;
`endif
    end else begin
`ifdef ALU_FAST_SHIFT_EN
      if (w_accept) begin
        r_result  <= w_res;
        r_zero    <= w_zero;
        r_illegal <= w_illegal;
      end
`else
      if (w_accept && w_start_iter) begin
        r_shreg <= w_res;
        r_cnt   <= w_shamt - SHAMT_WIDTH'(1);
        r_op    <= Operation;
      end else if (w_accept) begin
        r_result  <= w_res;
        r_zero    <= w_zero;
        r_illegal <= w_illegal;
      end else if (r_state == S_SHIFT) begin
        if (r_cnt == SHAMT_WIDTH'(1)) begin
          r_result  <= w_step;
          r_zero    <= (w_step == '0);
          r_illegal <= 1'b0;
        end else begin
          r_shreg <= w_step;
        end
        r_cnt <= r_cnt - SHAMT_WIDTH'(1);
      end
`endif
    end
  end

  assign ALUResult  = r_result;
  assign Zero       = r_zero;
  assign illegal_op = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_iterative.sv
// ============================================================================
//  Module   : tb_alu_iterative
//  Purpose  : Self-checking bench for alu_iterative (32-bit). Directed cases
//             followed by randomized ops compared against an arithmetic
//             reference model. Honours ALU_FAST_SHIFT_EN for shift latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_iterative;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        illegal_op;

  int n_vec;
  int n_err;

  alu_iterative #(.DATA_WIDTH(32)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Operation  (Operation),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the operation table.
  task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output logic ill);
    int sh;
    int sa;
    int sb;
    sh  = int'(b % 32);
    sa  = int'(a);
    sb  = int'(b);
    res = 32'h0;
    ill = 1'b0;
    case (op)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2:  res = a + b;
      4'd3:  res = a ^ b;
      4'd4:  res = a << sh;
      4'd5:  res = a >> sh;
      4'd6:  res = a - b;
      4'd7:  res = 32'(sa >>> sh);
      4'd8, 4'd9, 4'd10, 4'd11: res = a - b;
      4'd12: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd13: res = a + 32'd4;
      default: ill = 1'b1;
    endcase
    case (op)
      4'd8:  z = (a == b);
      4'd9:  z = (a != b);
      4'd10: z = (sa >= sb);
      4'd11: z = (sa < sb);
      4'd13, 4'd14, 4'd15: z = 1'b0;
      default: z = (res == 32'h0);
    endcase
  endtask

  function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && (b % 32) > 0) return int'(b % 32);
    return 1;
`endif
  endfunction

  // Issue one op with out_ready high, check latency, busy in_ready and
  // the result. Operands are scrambled after accept to prove capture.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] e_res;
    logic        e_z;
    logic        e_ill;
    int          lat;
    int          guard;
    ref_alu(op, a, b, e_res, e_z, e_ill);
    @(negedge clk);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    Operation = 4'($urandom);
    SrcA      = $urandom;
    SrcB      = $urandom;
    lat = 0;
    while (lat < 64) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      check({tag, "_busy_rdy"}, in_ready, 1'b0);
    end
    if (!out_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no out_valid expected valid", tag);
    end else begin
      check({tag, "_lat"}, lat, exp_latency(op, b));
      check({tag, "_res"}, ALUResult, e_res);
      check({tag, "_zero"}, Zero, e_z);
      check({tag, "_ill"}, illegal_op, e_ill);
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          seen;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Operation = 4'd0;
    SrcA      = 32'd0;
    SrcB      = 32'd0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", ALUResult, 32'h0);
    check("rst_zero", Zero, 1'b0);
    check("rst_illegal", illegal_op, 1'b0);

    // Back-to-back ADD then SUB
    Operation = 4'd2; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    Operation = 4'd6; SrcA = 32'd5; SrcB = 32'd7;
    @(negedge clk);
    check("b2b_add_valid", out_valid, 1'b1);
    check("b2b_add_res", ALUResult, 32'h0);
    check("b2b_add_zero", Zero, 1'b1);
    check("b2b_add_rdy", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_sub_valid", out_valid, 1'b1);
    check("b2b_sub_res", ALUResult, 32'hFFFF_FFFE);
    check("b2b_sub_zero", Zero, 1'b0);

    // Long SRA
    run_op("sra31", 4'd7, 32'h8000_0000, 32'd31);
    check("sra31_abs", ALUResult, 32'hFFFF_FFFF);

    // Branches and SLT with A = -1, B = 1
    run_op("blt", 4'd11, 32'hFFFF_FFFF, 32'd1);
    check("blt_taken", Zero, 1'b1);
    run_op("bge", 4'd10, 32'hFFFF_FFFF, 32'd1);
    check("bge_taken", Zero, 1'b0);
    run_op("beq", 4'd8, 32'hFFFF_FFFF, 32'd1);
    run_op("bne", 4'd9, 32'hFFFF_FFFF, 32'd1);
    run_op("slt", 4'd12, 32'hFFFF_FFFF, 32'd1);
    check("slt_abs", ALUResult, 32'd1);
    run_op("sll0", 4'd4, 32'h1234_5678, 32'h20);
    run_op("srl1", 4'd5, 32'h8000_0001, 32'd1);

    // Backpressure on JAL
    @(negedge clk);
    out_ready = 1'b0;
    Operation = 4'd13; SrcA = 32'h100; SrcB = 32'd0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    SrcA = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1'b1);
      check("bp_res", ALUResult, 32'h104);
      check("bp_zero", Zero, 1'b0);
      check("bp_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    run_op("illegal", 4'hF, 32'h5555_AAAA, 32'h1234);
    check("illegal_abs", illegal_op, 1'b1);

    // Reset in the middle of SLL by 10
    @(negedge clk);
    Operation = 4'd4; SrcA = 32'h0000_0F0F; SrcB = 32'd10; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_res", ALUResult, 32'h0);
    check("midrst_rdy", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 1'b0);
    run_op("post_rst_add", 4'd2, 32'd2, 32'd3);
    check("post_rst_abs", ALUResult, 32'd5);

    // Randomized ops against the reference model
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      run_op("rand", op, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
